mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Pipeline MEM stage: consumes the EX/MEM register outputs, runs the load/store handshake with the data memory
//  and registers the MEM/WB payload for writeback. Drives mem_stall to freeze the upstream registers while an
//  access is outstanding.
// PARAMETERS
//  TIMEOUT_CYCLES  16            max cycles in WAIT before a load is aborted (>=2)
//  MMIO_BASE       32'hF000_0000 MMIO region = addresses whose [31:28] match MMIO_BASE[31:28] (MMIO_EN only)
// PORTS
//  clk             in   1   clock, rising edge
//  reset_n         in   1   asynchronous active-low reset
//  in_reg_wr_en    in   1   instruction writes a register (0 = bubble)
//  in_mul_sel      in   2   writeback mux: 00 ALU, 01 load data, 10 PC+4, 11 ALU
//  in_alu_out      in   32  ALU result / memory byte address
//  in_data2_out    in   32  store data
//  in_pc           in   32  instruction PC
//  in_wr_reg       in   4   destination register index
//  in_is_load      in   1   load
//  in_is_store     in   1   store
//  mem_stall       out  1   hold EX/MEM and earlier stages (combinational)
//  dmem_req        out  1   memory request (combinational)
//  dmem_we         out  1   1 = write
//  dmem_addr       out  32  word-aligned byte address (= in_alu_out)
//  dmem_wdata      out  32  = in_data2_out
//  dmem_ready      in   1   request accepted this cycle
//  dmem_rvalid     in   1   read data valid
//  dmem_rdata      in   32  read data
//  out_reg_wr_en   out  1   MEM/WB: write enable
//  out_wr_reg      out  4   MEM/WB: destination index
//  out_wr_data     out  32  MEM/WB: writeback value
//  out_pc          out  32  MEM/WB: PC
//  mem_err         out  1   sticky: misaligned access or load timeout
// BEHAVIOUR
//  - Reset (async): state IDLE, timeout counter 0, all out_* and mem_err = 0.
//  - Memory op = in_is_load | in_is_store; in_is_load has priority if both are set (store ignored).
//  - Inputs are held stable by upstream while mem_stall=1; no input capture is done here.
//  - IDLE: op & aligned -> dmem_req=1, dmem_we=in_is_store. Store done when dmem_ready=1 (stall=0 that cycle).
//    Load accepted -> WAIT (stall=1). Request not accepted -> remain IDLE, stall=1, re-present the request.
//  - WAIT: dmem_req=0, stall=1 until dmem_rvalid; on rvalid stall=0, load completes with dmem_rdata, go to IDLE.
//    Counter increments each WAIT cycle; counter == TIMEOUT_CYCLES-1 with no rvalid -> mem_err=1, load
//    completes with out_reg_wr_en=0, go to IDLE. Counter clears on leaving WAIT.
//  - dmem_rvalid in IDLE is ignored (stale response after reset or abort).
//  - Misaligned (alu_out[1:0]!=0): no request, mem_err=1, completes in one cycle with out_reg_wr_en=0.
//  - MEM/WB register: loads on every cycle with stall=0; loads bubble (out_reg_wr_en=0, others hold) when stall=1.
//    out_wr_data: mul_sel 01 -> load data; 10 -> in_pc+4 (mod 2^32); else in_alu_out. Latency: 1 cycle for a
//    non-memory op or a store accepted in IDLE; 2+N cycles for a load with rvalid N cycles after acceptance.
//  - Reset mid-access: outstanding load is dropped, no writeback occurs.
// CONFIGURATION
//  MEM_ACCESS_MMIO_EN defined: adds ports io_wr_en out 1, io_wdata out 32, io_rdata in 32. An aligned op in the
//  MMIO region makes no dmem request: store pulses io_wr_en for one cycle with io_wdata=in_data2_out, load
//  returns io_rdata; both complete the same cycle with no stall. Undefined: ports are absent; all addresses
//  go to dmem.
// STRUCTURE
//  Package mem_access_pkg: state enum {IDLE, WAIT}; WB_SEL_ALU/WB_SEL_MEM/WB_SEL_PC4 constants; MMIO region
//  compare function. One sub-module, mem_wb_reg: async-reset MEM/WB payload register with a bubble input.
// TESTING
//  1. ALU op, mul_sel=00, alu_out=0x1234 -> next cycle out_wr_data=0x1234, out_reg_wr_en=1, mem_stall never 1.
//  2. Store addr 0x40, data 0xCAFE, dmem_ready=1 -> dmem_req/we=1 one cycle, no stall; out_reg_wr_en=0 if in=0.
//  3. Load addr 0x80, ready on 1st cycle, rvalid+0xBEEF 3 cycles later -> stall 4 cycles, out_wr_data=0xBEEF.
//  4. Load, rvalid never arrives, TIMEOUT_CYCLES=4 -> stall ends after 4 WAIT cycles, mem_err=1, no writeback.
//  5. Load to addr 0x81 -> no dmem_req, mem_err=1, out_reg_wr_en=0; reset_n low mid-WAIT -> all outputs 0.
//  6. MMIO_EN: store 0xF000_0004 data 0x5 -> io_wr_en=1, io_wdata=5, dmem_req=0; load returns io_rdata.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types and constants for the MEM pipeline stage.
// Holds the access FSM state enum, the writeback mux select codes and the
// MMIO region compare used when MEM_ACCESS_MMIO_EN is defined.
package mem_access_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  // An address is in the MMIO region when its top nibble matches the base.
  function automatic logic in_mmio_region(input logic [31:0] addr,
                                          input logic [31:0] base);
    return addr[31:28] == base[31:28];
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: data-memory request/response bus between the MEM stage
// (master) and the data memory (slave).
interface mem_access_if;
  import mem_access_pkg::*;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rvalid, dmem_rdata
  );

endinterface

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline payload register. Loads the payload every
// cycle; when bubble is set only the write enable is cleared and the rest
// of the payload holds its previous value.
module mem_wb_reg
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bubble,
  input  logic        in_reg_wr_en,
  input  logic [3:0]  in_wr_reg,
  input  logic [31:0] in_wr_data,
  input  logic [31:0] in_pc,
  output logic        out_reg_wr_en,
  output logic [3:0]  out_wr_reg,
  output logic [31:0] out_wr_data,
  output logic [31:0] out_pc
);

  // Payload register: full load when the stage advances, bubble otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg_wr_en <= 1'b0;
      out_wr_reg    <= 4'd0;
      out_wr_data   <= 32'd0;
      out_pc        <= 32'd0;
    end else if (bubble) begin
      out_reg_wr_en <= 1'b0;
    end else begin
      out_reg_wr_en <= in_reg_wr_en;
      out_wr_reg    <= in_wr_reg;
      out_wr_data   <= in_wr_data;
      out_pc        <= in_pc;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage. Runs the load/store handshake with
// the data memory, freezes upstream with mem_stall while an access is
// outstanding and feeds the MEM/WB register.
// Optional feature: define MEM_ACCESS_MMIO_EN to add the io_* ports; aligned
// accesses whose top nibble matches MMIO_BASE then bypass the data memory.
module mem_access_stage
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
`ifdef MEM_ACCESS_MMIO_EN
  , parameter logic [31:0] MMIO_BASE = 32'hF000_0000
`endif
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_reg_wr_en,
  input  logic [1:0]         in_mul_sel,
  input  logic [31:0]        in_alu_out,
  input  logic [31:0]        in_data2_out,
  input  logic [31:0]        in_pc,
  input  logic [3:0]         in_wr_reg,
  input  logic               in_is_load,
  input  logic               in_is_store,
  output logic               mem_stall,
  mem_access_if.master       dmem,
  output logic               out_reg_wr_en,
  output logic [3:0]         out_wr_reg,
  output logic [31:0]        out_wr_data,
  output logic [31:0]        out_pc,
`ifdef MEM_ACCESS_MMIO_EN
  output logic               io_wr_en,
  output logic [31:0]        io_wdata,
  input  logic [31:0]        io_rdata,
`endif
  output logic               mem_err
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt;
  logic          op, is_load, is_store, aligned, mmio_hit;
  logic          err_set, wb_en, io_wr;
  logic [31:0]   load_data, wb_data;

  assign op       = in_is_load | in_is_store;
  assign is_load  = in_is_load;
  assign is_store = in_is_store & ~in_is_load;
  assign aligned  = (in_alu_out[1:0] == 2'b00);

`ifdef MEM_ACCESS_MMIO_EN
  assign mmio_hit = in_mmio_region(in_alu_out, MMIO_BASE);
  assign io_wr_en = io_wr;
  assign io_wdata = in_data2_out;
`else
  assign mmio_hit = 1'b0;
`endif

  assign dmem.dmem_addr  = in_alu_out;
  assign dmem.dmem_wdata = in_data2_out;

  // State, wait counter (clears whenever WAIT is left) and sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == WAIT && state_next == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (err_set) begin
        mem_err <= 1'b1;
      end
    end
  end

  // Next state, memory handshake, stall and writeback enable/data source.
  always_comb begin
    state_next     = state;
    mem_stall      = 1'b0;
    dmem.dmem_req  = 1'b0;
    dmem.dmem_we   = 1'b0;
    wb_en          = in_reg_wr_en;
    load_data      = dmem.dmem_rdata;
    err_set        = 1'b0;
    io_wr          = 1'b0;
    case (state)
      IDLE: begin
        if (op) begin
          if (!aligned) begin
            wb_en   = 1'b0;
            err_set = 1'b1;
          end else if (mmio_hit) begin
            io_wr = is_store;
`ifdef MEM_ACCESS_MMIO_EN
            load_data = io_rdata;
`endif
          end else begin
            dmem.dmem_req = 1'b1;
            dmem.dmem_we  = is_store;
            if (!dmem.dmem_ready) begin
              mem_stall = 1'b1;
            end else if (is_load) begin
              mem_stall  = 1'b1;
              state_next = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (dmem.dmem_rvalid) begin
          state_next = IDLE;
        end else if (wait_cnt == TO_LAST) begin
          err_set    = 1'b1;
          wb_en      = 1'b0;
          state_next = IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Writeback value selection.
  always_comb begin
    wb_data = in_alu_out;
    case (in_mul_sel)
      WB_SEL_MEM: wb_data = load_data;
      WB_SEL_PC4: wb_data = in_pc + 32'd4;
      WB_SEL_ALU: wb_data = in_alu_out;
      default:    wb_data = in_alu_out;
    endcase
  end

  mem_wb_reg u_mem_wb_reg (
    .clk          (clk),
    .reset_n      (reset_n),
    .bubble       (mem_stall),
    .in_reg_wr_en (wb_en),
    .in_wr_reg    (in_wr_reg),
    .in_wr_data   (wb_data),
    .in_pc        (in_pc),
    .out_reg_wr_en(out_reg_wr_en),
    .out_wr_reg   (out_wr_reg),
    .out_wr_data  (out_wr_data),
    .out_pc       (out_pc)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed bench for mem_access_stage built with
// TIMEOUT_CYCLES=4. MMIO steps compile in only with MEM_ACCESS_MMIO_EN.
module tb_mem_access_stage;
  import mem_access_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        in_reg_wr_en;
  logic [1:0]  in_mul_sel;
  logic [31:0] in_alu_out;
  logic [31:0] in_data2_out;
  logic [31:0] in_pc;
  logic [3:0]  in_wr_reg;
  logic        in_is_load;
  logic        in_is_store;
  logic        mem_stall;
  logic        out_reg_wr_en;
  logic [3:0]  out_wr_reg;
  logic [31:0] out_wr_data;
  logic [31:0] out_pc;
  logic        mem_err;
`ifdef MEM_ACCESS_MMIO_EN
  logic        io_wr_en;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
`endif

  int checks = 0;
  int passes = 0;

  mem_access_if dif ();

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_reg_wr_en (in_reg_wr_en),
    .in_mul_sel   (in_mul_sel),
    .in_alu_out   (in_alu_out),
    .in_data2_out (in_data2_out),
    .in_pc        (in_pc),
    .in_wr_reg    (in_wr_reg),
    .in_is_load   (in_is_load),
    .in_is_store  (in_is_store),
    .mem_stall    (mem_stall),
    .dmem         (dif),
    .out_reg_wr_en(out_reg_wr_en),
    .out_wr_reg   (out_wr_reg),
    .out_wr_data  (out_wr_data),
    .out_pc       (out_pc),
`ifdef MEM_ACCESS_MMIO_EN
    .io_wr_en     (io_wr_en),
    .io_wdata     (io_wdata),
    .io_rdata     (io_rdata),
`endif
    .mem_err      (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wr_en, input logic [1:0] sel,
                               input logic [31:0] alu, input logic [31:0] d2,
                               input logic [31:0] pc, input logic [3:0] rd,
                               input logic ld, input logic st);
    in_reg_wr_en = wr_en;
    in_mul_sel   = sel;
    in_alu_out   = alu;
    in_data2_out = d2;
    in_pc        = pc;
    in_wr_reg    = rd;
    in_is_load   = ld;
    in_is_store  = st;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic bubble();
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    dif.dmem_ready  = 1'b0;
    dif.dmem_rvalid = 1'b0;
    dif.dmem_rdata  = 32'd0;
`ifdef MEM_ACCESS_MMIO_EN
    io_rdata = 32'd0;
`endif
    bubble();
    #10;
    checkOutput("reset_wr_en", out_reg_wr_en, 0);
    checkOutput("reset_wr_data", out_wr_data, 0);
    checkOutput("reset_err", mem_err, 0);
    checkOutput("reset_stall", mem_stall, 0);
    reset_n = 1'b1;

    // ALU op, mul_sel 00
    tick();
    applyStimulus(1'b1, 2'b00, 32'h1234, 32'd0, 32'h100, 4'd3, 1'b0, 1'b0);
    checkOutput("alu_stall", mem_stall, 0);
    checkOutput("alu_req", dif.dmem_req, 0);
    tick();
    checkOutput("alu_wr_en", out_reg_wr_en, 1);
    checkOutput("alu_data", out_wr_data, 32'h1234);
    checkOutput("alu_reg", out_wr_reg, 3);
    checkOutput("alu_pc", out_pc, 32'h100);

    // PC+4 with wraparound
    applyStimulus(1'b1, 2'b10, 32'h5555, 32'd0, 32'hFFFF_FFFC, 4'd7, 1'b0, 1'b0);
    tick();
    checkOutput("pc4_wrap", out_wr_data, 32'd0);
    // mul_sel 11 selects ALU
    applyStimulus(1'b1, 2'b11, 32'hA5A5, 32'd0, 32'h200, 4'd2, 1'b0, 1'b0);
    tick();
    checkOutput("sel11_data", out_wr_data, 32'hA5A5);

    // Store accepted immediately
    dif.dmem_ready = 1'b1;
    applyStimulus(1'b0, 2'b00, 32'h40, 32'hCAFE, 32'h300, 4'd1, 1'b0, 1'b1);
    checkOutput("st_req", dif.dmem_req, 1);
    checkOutput("st_we", dif.dmem_we, 1);
    checkOutput("st_addr", dif.dmem_addr, 32'h40);
    checkOutput("st_wdata", dif.dmem_wdata, 32'hCAFE);
    checkOutput("st_stall", mem_stall, 0);
    tick();
    checkOutput("st_wr_en", out_reg_wr_en, 0);
    bubble();
    checkOutput("st_req_drop", dif.dmem_req, 0);

    // Store not accepted on first try: stall, re-present
    dif.dmem_ready = 1'b0;
    applyStimulus(1'b1, 2'b00, 32'h44, 32'h1, 32'h304, 4'd4, 1'b0, 1'b1);
    checkOutput("st_wait_stall", mem_stall, 1);
    checkOutput("st_wait_req", dif.dmem_req, 1);
    tick();
    checkOutput("st_wait_bubble", out_reg_wr_en, 0);
    dif.dmem_ready = 1'b1;
    #1;
    checkOutput("st_acc_stall", mem_stall, 0);
    tick();
    checkOutput("st_acc_wr_en", out_reg_wr_en, 1);
    checkOutput("st_acc_data", out_wr_data, 32'h44);

    // Load at 0x80, rvalid on the 4th WAIT cycle (also the timeout cycle)
    dif.dmem_ready = 1'b1;
    applyStimulus(1'b1, 2'b01, 32'h80, 32'd0, 32'h400, 4'd5, 1'b1, 1'b0);
    checkOutput("ld_req", dif.dmem_req, 1);
    checkOutput("ld_we", dif.dmem_we, 0);
    checkOutput("ld_acc_stall", mem_stall, 1);
    tick();
    checkOutput("ld_bubble", out_reg_wr_en, 0);
    dif.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("ld_wait_stall%0d", i), mem_stall, 1);
      checkOutput($sformatf("ld_wait_req%0d", i), dif.dmem_req, 0);
      tick();
    end
    dif.dmem_rvalid = 1'b1;
    dif.dmem_rdata  = 32'hBEEF;
    #1;
    checkOutput("ld_rv_stall", mem_stall, 0);
    tick();
    dif.dmem_rvalid = 1'b0;
    checkOutput("ld_wr_en", out_reg_wr_en, 1);
    checkOutput("ld_data", out_wr_data, 32'hBEEF);
    checkOutput("ld_reg", out_wr_reg, 5);
    checkOutput("ld_err", mem_err, 0);

    // Stale rvalid in IDLE is ignored; then load times out
    dif.dmem_ready  = 1'b0;
    dif.dmem_rvalid = 1'b1;
    dif.dmem_rdata  = 32'h1111;
    applyStimulus(1'b1, 2'b01, 32'h84, 32'd0, 32'h500, 4'd6, 1'b1, 1'b0);
    checkOutput("stale_rv_stall", mem_stall, 1);
    tick();
    dif.dmem_rvalid = 1'b0;
    dif.dmem_ready  = 1'b1;
    #1;
    checkOutput("to_acc_stall", mem_stall, 1);
    tick();
    dif.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("to_wait_stall%0d", i), mem_stall, 1);
      tick();
    end
    #1;
    checkOutput("to_end_stall", mem_stall, 0);
    tick();
    checkOutput("to_wr_en", out_reg_wr_en, 0);
    checkOutput("to_err", mem_err, 1);
    applyStimulus(1'b1, 2'b00, 32'h99, 32'd0, 32'h600, 4'd8, 1'b0, 1'b0);
    checkOutput("to_idle_stall", mem_stall, 0);
    tick();
    checkOutput("to_after_data", out_wr_data, 32'h99);
    checkOutput("err_sticky", mem_err, 1);

    // Misaligned load
    doReset();
    checkOutput("rst_err_clr", mem_err, 0);
    dif.dmem_ready = 1'b1;
    applyStimulus(1'b1, 2'b01, 32'h81, 32'd0, 32'h700, 4'd9, 1'b1, 1'b0);
    checkOutput("mis_req", dif.dmem_req, 0);
    checkOutput("mis_stall", mem_stall, 0);
    tick();
    checkOutput("mis_wr_en", out_reg_wr_en, 0);
    checkOutput("mis_err", mem_err, 1);

    // Reset in the middle of WAIT drops the load
    doReset();
    applyStimulus(1'b1, 2'b00, 32'h77, 32'd0, 32'h800, 4'd10, 1'b0, 1'b0);
    tick();
    checkOutput("pre_rst_data", out_wr_data, 32'h77);
    applyStimulus(1'b1, 2'b01, 32'h88, 32'd0, 32'h804, 4'd11, 1'b1, 1'b0);
    tick();
    dif.dmem_ready = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_wr_en", out_reg_wr_en, 0);
    checkOutput("rst_mid_data", out_wr_data, 0);
    checkOutput("rst_mid_pc", out_pc, 0);
    checkOutput("rst_mid_err", mem_err, 0);
    bubble();
    reset_n = 1'b1;
    dif.dmem_rvalid = 1'b1;
    dif.dmem_rdata  = 32'hDEAD;
    #1;
    checkOutput("rst_drop_stall", mem_stall, 0);
    tick();
    dif.dmem_rvalid = 1'b0;
    checkOutput("rst_drop_wr_en", out_reg_wr_en, 0);
    checkOutput("rst_drop_data", out_wr_data, 0);

`ifdef MEM_ACCESS_MMIO_EN
    // MMIO store and load bypass the data memory
    applyStimulus(1'b0, 2'b00, 32'hF000_0004, 32'h5, 32'h900, 4'd1, 1'b0, 1'b1);
    checkOutput("io_wr_en", io_wr_en, 1);
    checkOutput("io_wdata", io_wdata, 32'h5);
    checkOutput("io_st_req", dif.dmem_req, 0);
    checkOutput("io_st_stall", mem_stall, 0);
    tick();
    io_rdata = 32'h1357;
    applyStimulus(1'b1, 2'b01, 32'hF000_0008, 32'd0, 32'h904, 4'd2, 1'b1, 1'b0);
    checkOutput("io_ld_req", dif.dmem_req, 0);
    checkOutput("io_ld_stall", mem_stall, 0);
    tick();
    checkOutput("io_ld_data", out_wr_data, 32'h1357);
    checkOutput("io_ld_wr_en", out_reg_wr_en, 1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
